// File: rtl/pkt_arb_pkg.sv
// pkt_arb_pkg: shared types, counter width and index helper for the packet round-robin arbiter
package pkt_arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    localparam int CNT_W = 16;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pkt_rr_arbiter_first_rr_pick.sv
// rr_pick: combinational round-robin pick of the first set request at or above ptr, with wrap
module rr_pick #(
    parameter int n_req = 4,
    localparam int IW = $clog2(n_req)
) (
    input  logic [n_req-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [n_req-1:0] grant,
    output logic [IW-1:0]    index,
    output logic             any
);

    logic [IW-1:0] cand;

    // Scan from the farthest candidate down so the nearest one to ptr wins.
    always_comb begin
        index = '0;
        cand  = '0;
        for (int k = n_req - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % n_req);
            if (req[cand]) index = cand;
        end
    end

    assign any   = |req;
    assign grant = any ? (n_req'(1) << index) : '0;

endmodule

// File: rtl/pkt_rr_arbiter_first.sv
// pkt_rr_arbiter_first: packet-atomic round-robin arbiter onto a first-tagged valid/data stream.
// Define PKT_ARB_STATS_EN to add per-requester completed-packet counters on pkt_count.
module pkt_rr_arbiter_first
    import pkt_arb_pkg::*;
#(
    parameter int width = 8,
    parameter int n_req = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [n_req-1:0]       req_valid,
    input  logic [n_req-1:0]       req_last,
    input  logic [n_req*width-1:0] req_data,
    output logic [n_req-1:0]       req_ready,
    output logic                   down_valid,
    output logic                   down_first,
    output logic [width-1:0]       down_data,
`ifdef PKT_ARB_STATS_EN
    output logic [n_req*CNT_W-1:0] pkt_count,
`endif
    output logic                   busy
);

    localparam int IW = $clog2(n_req);

    arb_state_t        state;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     rr_ptr;
    logic [n_req-1:0]  pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [IW-1:0]     winner;
    logic              acc;
    logic              acc_last;

    rr_pick #(.n_req(n_req)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .index (pick_idx),
        .any   (pick_any)
    );

    // The owner keeps ready high through bubbles so the grant is never lost mid-packet.
    always_comb begin
        winner    = (state == IDLE) ? pick_idx : owner;
        req_ready = (state == IDLE) ? pick_grant : (n_req'(1) << owner);
        acc       = (state == IDLE) ? pick_any : req_valid[owner];
        acc_last  = acc & req_last[winner];
    end

    assign busy = (state == BUSY);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            down_valid <= 1'b0;
            down_first <= 1'b0;
            down_data  <= '0;
        end else begin
            down_valid <= acc;
            down_first <= acc & (state == IDLE);
            if (acc) down_data <= req_data[winner*width +: width];
            if (acc_last) begin
                state  <= IDLE;
                rr_ptr <= IW'(wrap_inc(32'(winner), 32'(n_req)));
            end else if (acc && state == IDLE) begin
                state <= BUSY;
                owner <= pick_idx;
            end
        end
    end

`ifdef PKT_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) pkt_count <= '0;
        else if (acc_last) pkt_count[winner*CNT_W +: CNT_W] <= pkt_count[winner*CNT_W +: CNT_W] + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_pkt_rr_arbiter_first.sv
// tb_pkt_rr_arbiter_first: directed self-checking bench for pkt_rr_arbiter_first
module tb_pkt_rr_arbiter_first;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        down_valid;
    logic        down_first;
    logic [7:0]  down_data;
    logic        busy;
`ifdef PKT_ARB_STATS_EN
    logic [63:0] pkt_count;
`endif

    int checks = 0;
    int failures = 0;

    pkt_rr_arbiter_first #(.width(8), .n_req(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .down_valid (down_valid),
        .down_first (down_first),
        .down_data  (down_data),
`ifdef PKT_ARB_STATS_EN
        .pkt_count  (pkt_count),
`endif
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [7:0] d);
        req_valid[i]       = v;
        req_last[i]        = l;
        req_data[i*8 +: 8] = d;
    endtask

    task automatic check_down(input string tag, input logic v, input logic f, input logic [7:0] d, input logic b);
        check({tag, "_valid"}, 64'(down_valid), 64'(v));
        check({tag, "_first"}, 64'(down_first), 64'(f));
        check({tag, "_data"},  64'(down_data),  64'(d));
        check({tag, "_busy"},  64'(busy),       64'(b));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        tick();
        tick();
        check_down("reset", 0, 0, 8'h00, 0);
        reset = 1'b0;
        // idle for 10 cycles
        for (int c = 0; c < 10; c++) begin
            #1;
            check("idle_ready", 64'(req_ready), 64'h0);
            tick();
            check("idle_valid", 64'(down_valid), 64'h0);
            check("idle_busy", 64'(busy), 64'h0);
        end
        // single 3-beat packet from requester 2
        set_req(2, 1, 0, 8'hA1);
        #1;
        check("single_ready", 64'(req_ready), 64'h4);
        tick();
        check_down("single_a1", 1, 1, 8'hA1, 1);
        set_req(2, 1, 0, 8'hA2);
        tick();
        check_down("single_a2", 1, 0, 8'hA2, 1);
        set_req(2, 1, 1, 8'hA3);
        tick();
        check_down("single_a3", 1, 0, 8'hA3, 0);
        set_req(2, 0, 0, 8'h55);
        tick();
        check_down("single_hold", 0, 0, 8'hA3, 0);
        // contention: all four hold single-beat packets, order 0,1,2,3 from a fresh pointer
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1, 1, 8'(8'h10 + i));
        for (int c = 0; c < 8; c++) begin
            #1;
            check("cont_ready", 64'(req_ready), 64'(4'b0001 << (c % 4)));
            tick();
            check_down("cont", 1, 1, 8'(8'h10 + (c % 4)), 0);
        end
        req_valid = '0;
        req_last = '0;
        tick();
        // atomicity: requester 0 4-beat packet with 2-cycle gap, requester 1 waiting throughout
        set_req(1, 1, 1, 8'h11);
        set_req(0, 1, 0, 8'h01);
        #1;
        check("atom_b1_ready", 64'(req_ready), 64'h1);
        tick();
        check_down("atom_b1", 1, 1, 8'h01, 1);
        set_req(0, 1, 0, 8'h02);
        #1;
        check("atom_b2_ready", 64'(req_ready), 64'h1);
        tick();
        check_down("atom_b2", 1, 0, 8'h02, 1);
        set_req(0, 0, 1, 8'hEE);
        for (int g = 0; g < 2; g++) begin
            #1;
            check("atom_gap_ready", 64'(req_ready), 64'h1);
            tick();
            check_down("atom_gap", 0, 0, 8'h02, 1);
        end
        set_req(0, 1, 0, 8'h03);
        tick();
        check_down("atom_b3", 1, 0, 8'h03, 1);
        set_req(0, 1, 1, 8'h04);
        #1;
        check("atom_b4_ready", 64'(req_ready), 64'h1);
        tick();
        check_down("atom_b4", 1, 0, 8'h04, 0);
        set_req(0, 0, 0, 8'h00);
        #1;
        check("atom_r1_ready", 64'(req_ready), 64'h2);
        tick();
        check_down("atom_r1", 1, 1, 8'h11, 0);
        req_valid = '0;
        req_last = '0;
        tick();
        // reset mid-packet: pointer is now 2, so requester 3 wins over requester 0
        set_req(0, 1, 0, 8'h20);
        set_req(3, 1, 0, 8'h31);
        #1;
        check("rst_b1_ready", 64'(req_ready), 64'h8);
        tick();
        check_down("rst_b1", 1, 1, 8'h31, 1);
        set_req(3, 1, 0, 8'h32);
        tick();
        check_down("rst_b2", 1, 0, 8'h32, 1);
        reset = 1'b1;
        tick();
        check_down("rst_mid", 0, 0, 8'h00, 0);
        reset = 1'b0;
        #1;
        check("rst_after_ready", 64'(req_ready), 64'h1);
        tick();
        check_down("rst_after", 1, 1, 8'h20, 1);
        req_valid = '0;
        set_req(0, 1, 1, 8'h21);
        tick();
        check_down("rst_after_last", 1, 0, 8'h21, 0);
        req_valid = '0;
        req_last = '0;
        tick();
        // stats: three packets from requester 1, one from requester 3
        do_reset();
        set_req(1, 1, 1, 8'h41);
        tick();
        check_down("stat_p1", 1, 1, 8'h41, 0);
        tick();
        tick();
        req_valid = '0;
        set_req(3, 1, 1, 8'h43);
        tick();
        check_down("stat_p3", 1, 1, 8'h43, 0);
        req_valid = '0;
        req_last = '0;
        tick();
`ifdef PKT_ARB_STATS_EN
        check("stat_count", pkt_count, 64'h0001_0000_0003_0000);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
